// File: rtl/alu_32b.sv
// Registered integer ALU for the execute stage: logic, add/sub, signed SLT and
// equality, with carry/zero/overflow flags captured one clock after in_valid.
module alu_32b #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A_in,
  input  logic [WIDTH-1:0] B_in,
  input  logic [3:0]       ALU_Sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] ALU_Out,
  output logic             Carry_Out,
  output logic             Zero,
  output logic             Overflow
);

  typedef enum logic [3:0] {
    OP_AND = 4'b0000,
    OP_OR  = 4'b0001,
    OP_ADD = 4'b0010,
    OP_SUB = 4'b0110,
    OP_SLT = 4'b0111,
    OP_NOR = 4'b1100,
    OP_EQ  = 4'b1111
  } alu_op_e;

  logic [WIDTH:0]   add_full;
  logic [WIDTH:0]   sub_full;
  logic             slt_bit;
  logic [WIDTH-1:0] res_next;
  logic             carry_next;
  logic             ovf_next;
  logic             zero_next;

  assign add_full = {1'b0, A_in} + {1'b0, B_in};
  assign sub_full = {1'b0, A_in} + {1'b0, ~B_in} + {{WIDTH{1'b0}}, 1'b1};
  // Exact signed compare, independent of subtract overflow.
  assign slt_bit  = ($signed(A_in) < $signed(B_in));

  always_comb begin
    res_next   = '0;
    carry_next = 1'b0;
    ovf_next   = 1'b0;
    case (ALU_Sel)
      OP_AND: res_next = A_in & B_in;
      OP_OR:  res_next = A_in | B_in;
      OP_ADD: begin
        res_next   = add_full[WIDTH-1:0];
        carry_next = add_full[WIDTH];
        ovf_next   = (A_in[WIDTH-1] == B_in[WIDTH-1]) &&
                     (add_full[WIDTH-1] != A_in[WIDTH-1]);
      end
      OP_SUB: begin
        res_next   = sub_full[WIDTH-1:0];
        carry_next = sub_full[WIDTH];
        ovf_next   = (A_in[WIDTH-1] != B_in[WIDTH-1]) &&
                     (sub_full[WIDTH-1] != A_in[WIDTH-1]);
      end
      OP_SLT: res_next = {{(WIDTH-1){1'b0}}, slt_bit};
      OP_NOR: res_next = ~(A_in | B_in);
      OP_EQ:  res_next = {{(WIDTH-1){1'b0}}, (A_in == B_in)};
      default: res_next = '0;
    endcase
    zero_next = (res_next == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      ALU_Out   <= '0;
      Carry_Out <= 1'b0;
      Zero      <= 1'b1;
      Overflow  <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        ALU_Out   <= res_next;
        Carry_Out <= carry_next;
        Zero      <= zero_next;
        Overflow  <= ovf_next;
      end
    end
  end

endmodule

// File: tb/tb_alu_32b.sv
// Scoreboard bench for alu_32b: directed vectors queue their hand-computed
// results; a negedge monitor pops and compares whenever out_valid is high.
module tb_alu_32b;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] A_in;
  logic [31:0] B_in;
  logic [3:0]  ALU_Sel;
  logic        out_valid;
  logic [31:0] ALU_Out;
  logic        Carry_Out;
  logic        Zero;
  logic        Overflow;

  alu_32b #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .A_in(A_in), .B_in(B_in),
    .ALU_Sel(ALU_Sel), .out_valid(out_valid), .ALU_Out(ALU_Out),
    .Carry_Out(Carry_Out), .Zero(Zero), .Overflow(Overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] r;
    logic        c;
    logic        z;
    logic        o;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  logic exp_ov   = 1'b0;
  exp_t last;

  task automatic chk(input string name, input logic [34:0] act, input logic [34:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // out_valid model: high exactly one cycle after an accepted, non-reset input.
  always @(posedge clk) exp_ov <= in_valid && rst_n;

  always @(negedge clk) begin
    exp_t e;
    if (rst_n !== 1'bx) begin
      chk("out_valid", {34'd0, out_valid}, {34'd0, exp_ov});
      if (out_valid === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_output", 35'd1, 35'd0);
        end else begin
          e = sb.pop_front();
          chk(e.name, {ALU_Out, Carry_Out, Zero, Overflow}, {e.r, e.c, e.z, e.o});
        end
      end
    end
  end

  task automatic issue(input string name, input logic [3:0] sel, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] r, input logic c,
                       input logic z, input logic o);
    exp_t e;
    @(posedge clk); #1;
    in_valid = 1'b1; ALU_Sel = sel; A_in = a; B_in = b;
    e.name = name; e.r = r; e.c = c; e.z = z; e.o = o;
    sb.push_back(e);
    last = e;
  endtask

  task automatic idle();
    @(posedge clk); #1;
    in_valid = 1'b0;
    A_in = $urandom; B_in = $urandom; ALU_Sel = 4'b0010;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; A_in = '0; B_in = '0; ALU_Sel = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_state", {ALU_Out, Carry_Out, Zero, Overflow}, {32'h0, 1'b0, 1'b1, 1'b0});

    issue("and",       4'b0000, 32'hA5002D77, 32'hF14C0A81, 32'hA1000801, 0, 0, 0);
    issue("or",        4'b0001, 32'h8086F09D, 32'h4E1B0072, 32'hCE9FF0FF, 0, 0, 0);
    issue("add_c",     4'b0010, 32'hC182F088, 32'hD07915C2, 32'h91FC064A, 1, 0, 0);
    issue("add_ovf",   4'b0010, 32'h4182F088, 32'h507915C3, 32'h91FC064B, 0, 0, 1);
    issue("sub_brw",   4'b0110, 32'hC182F088, 32'hD07915C2, 32'hF109DAC6, 0, 0, 0);
    issue("sub_ovf",   4'b0110, 32'hB182F088, 32'h707915C3, 32'h4109DAC5, 1, 0, 1);
    issue("slt_neg",   4'b0111, 32'hFFFFFFF9, 32'h00000006, 32'h00000001, 0, 0, 0);
    issue("nor_zero",  4'b1100, 32'hE491C062, 32'h5B7E7F9D, 32'h00000000, 0, 1, 0);
    issue("eq_true",   4'b1111, 32'h00000001, 32'h00000001, 32'h00000001, 0, 0, 0);
    issue("eq_false",  4'b1111, 32'h00000001, 32'h00000002, 32'h00000000, 0, 1, 0);
    issue("illegal",   4'b0101, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 0, 1, 0);
    issue("add_maxp",  4'b0010, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 0, 0, 1);
    issue("add_wrap",  4'b0010, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1, 1, 0);
    issue("sub_eq",    4'b0110, 32'h12345678, 32'h12345678, 32'h00000000, 1, 1, 0);
    issue("sub_minn",  4'b0110, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1, 0, 1);
    issue("slt_ovf",   4'b0111, 32'h80000000, 32'h7FFFFFFF, 32'h00000001, 0, 0, 0);
    issue("slt_false", 4'b0111, 32'h7FFFFFFF, 32'h80000000, 32'h00000000, 0, 1, 0);
    issue("and_flags", 4'b0000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0);
    issue("sub_hold",  4'b0110, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 0, 0, 0);

    idle();
    idle();
    @(negedge clk);
    chk("hold", {ALU_Out, Carry_Out, Zero, Overflow}, {last.r, last.c, last.z, last.o});

    issue("pre_reset", 4'b0010, 32'h00000003, 32'h00000004, 32'h00000007, 0, 0, 0);
    @(posedge clk); #1;
    rst_n = 1'b0; in_valid = 1'b1; ALU_Sel = 4'b0001; A_in = 32'h0000FFFF; B_in = 32'h1;
    @(posedge clk); #1;
    rst_n = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    chk("mid_reset", {ALU_Out, Carry_Out, Zero, Overflow}, {32'h0, 1'b0, 1'b1, 1'b0});

    issue("post_reset", 4'b0001, 32'h0000F0F0, 32'h00000F0F, 32'h0000FFFF, 0, 0, 0);
    idle();
    repeat (3) @(negedge clk);
    chk("sb_drained", {3'd0, 32'(sb.size())}, 35'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
